// File: rtl/reg_file.sv
// Configuration/operand register file: single-cycle writes, registered reads with a one-cycle
// valid pulse, and the first four registers exported continuously to ALU, UART and clock divider.
module reg_file #(
    parameter int unsigned Data_width    = 8,
    parameter int unsigned Address_width = 4,
    parameter int unsigned Depth         = 16,
    parameter logic [Data_width-1:0] REG2_RST = 8'h81,
    parameter logic [Data_width-1:0] REG3_RST = 8'h20
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     WrEn,
    input  logic                     RdEn,
    input  logic [Address_width-1:0] Addr,
    input  logic [Data_width-1:0]    Wr_Data,
    output logic [Data_width-1:0]    Rd_Data,
    output logic                     Rd_Data_valid,
    output logic [Data_width-1:0]    REG0,
    output logic [Data_width-1:0]    REG1,
    output logic [Data_width-1:0]    REG2,
    output logic [Data_width-1:0]    REG3
);

    logic [Data_width-1:0] mem [Depth];
    logic [Data_width-1:0] rd_mux;

    function automatic logic [Data_width-1:0] rst_val(input int unsigned idx);
        if (idx == 2) begin
            return REG2_RST;
        end else if (idx == 3) begin
            return REG3_RST;
        end else begin
            return '0;
        end
    endfunction

    // Decoding by comparison rather than indexing drops out-of-range writes and returns 0 on
    // out-of-range reads whenever Depth < 2**Address_width.
    always_comb begin
        rd_mux = '0;
        for (int unsigned i = 0; i < Depth; i++) begin
            if (Addr == i[Address_width-1:0]) begin
                rd_mux = mem[i];
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int unsigned i = 0; i < Depth; i++) begin
                mem[i] <= rst_val(i);
            end
        end else if (WrEn) begin
            for (int unsigned i = 0; i < Depth; i++) begin
                if (Addr == i[Address_width-1:0]) begin
                    mem[i] <= Wr_Data;
                end
            end
        end
    end

    // A write takes priority over a simultaneous read; Rd_Data holds unless a read completes.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            Rd_Data       <= '0;
            Rd_Data_valid <= 1'b0;
        end else if (WrEn) begin
            Rd_Data_valid <= 1'b0;
        end else if (RdEn) begin
            Rd_Data       <= rd_mux;
            Rd_Data_valid <= 1'b1;
        end else begin
            Rd_Data_valid <= 1'b0;
        end
    end

    assign REG0 = mem[0];
    assign REG1 = mem[1];
    assign REG2 = mem[2];
    assign REG3 = mem[3];

endmodule
